tlul_sram_responder: RTL and testbench



---
 rtl/tlul_sram_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_tlul_sram_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_sram_responder.sv
// TL-UL device-side SRAM responder with configurable read latency and bounded outstanding requests.
// Optional macro TLUL_RSP_ALIGN_CHECK_EN adds size/alignment/mask legality checks on A-channel requests.
package tlul_pkg;
   localparam int TL_DW = 32;

   localparam logic [2:0] OP_PUT_FULL    = 3'h0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'h1;
   localparam logic [2:0] OP_GET         = 3'h4;
   localparam logic [2:0] OP_ACK         = 3'h0;
   localparam logic [2:0] OP_ACK_DATA    = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module tlul_sram_responder
   import tlul_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          MEM_WORDS   = 256,
   parameter int          RSP_LATENCY = 1,
   parameter int          RSP_DEPTH   = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  tl_h2d_t                            tl_i,
   output tl_d2h_t                            tl_o,
   output logic [$clog2(RSP_DEPTH+1)-1:0]     outstanding_o
);

   localparam int BW  = TL_DW / 8;
   localparam int LSB = $clog2(BW);
   localparam int AW  = $clog2(MEM_WORDS);
   localparam int OW  = $clog2(RSP_DEPTH + 1);
   localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam logic [31:0]   WIN_BYTES = 32'(MEM_WORDS * BW);
   localparam logic [OW-1:0] DEPTH_C   = OW'(RSP_DEPTH);
   localparam logic [PW-1:0] LAST_PTR  = PW'(RSP_DEPTH - 1);

   typedef struct packed {
      logic [2:0]  opcode;
      logic [1:0]  size;
      logic [7:0]  source;
      logic [31:0] data;
      logic        error;
   } rsp_t;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? {PW{1'b0}} : p + 1'b1;
   endfunction

`ifdef TLUL_RSP_ALIGN_CHECK_EN
   // Legality of size, address alignment and mask for a 32-bit data bus.
   function automatic logic align_bad(input logic [2:0] op, input logic [1:0] size,
                                      input logic [1:0] lo, input logic [3:0] mask);
      logic [3:0] lanes;
      logic [1:0] lo_mask;
      logic       bad;
      case (size)
         2'd0:    begin lanes = 4'b0001; lo_mask = 2'b00; end
         2'd1:    begin lanes = 4'b0011; lo_mask = 2'b01; end
         2'd2:    begin lanes = 4'b1111; lo_mask = 2'b11; end
         default: begin lanes = 4'b0000; lo_mask = 2'b11; end
      endcase
      bad = (size > 2'd2) || ((lo & lo_mask) != 2'b00);
      bad = bad || ((op == OP_PUT_FULL) && (mask != 4'(lanes << lo)));
      bad = bad || ((op == OP_GET) && (mask == 4'b0000));
      return bad;
   endfunction
`endif

   logic [TL_DW-1:0] mem [MEM_WORDS];

   logic [31:0]   off_s;
   logic [AW-1:0] idx_s;
   logic          is_get_s;
   logic          is_put_s;
   logic          err_s;
   logic          accept_s;
   logic          wr_en_s;
   logic          hs_s;
   logic          push_s;
   logic [OW-1:0] out_next_s;
   rsp_t          new_rsp_s;

   rsp_t             pipe_r [RSP_LATENCY];
   logic [RSP_LATENCY-1:0] pipe_vld_r;
   rsp_t             fifo_r [RSP_DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [OW-1:0]    cnt_r;
   logic [OW-1:0]    out_r;
   logic             a_ready_r;

   logic unused_bits;
   assign unused_bits = ^tl_i.a_param;

   // Request decode: range/opcode errors, handshake strobes and the response to enqueue.
   always_comb begin
      off_s    = tl_i.a_address - BASE_ADDR;
      idx_s    = off_s[AW+LSB-1:LSB];
      is_get_s = (tl_i.a_opcode == OP_GET);
      is_put_s = (tl_i.a_opcode == OP_PUT_FULL) || (tl_i.a_opcode == OP_PUT_PARTIAL);
      err_s    = !(is_get_s || is_put_s) || !(off_s < WIN_BYTES);
`ifdef TLUL_RSP_ALIGN_CHECK_EN
      err_s    = err_s || align_bad(tl_i.a_opcode, tl_i.a_size, tl_i.a_address[1:0], tl_i.a_mask);
`endif
      accept_s = tl_i.a_valid && a_ready_r;
      wr_en_s  = accept_s && is_put_s && !err_s;
      hs_s     = (cnt_r != {OW{1'b0}}) && tl_i.d_ready;
      push_s   = pipe_vld_r[RSP_LATENCY-1];
      out_next_s = out_r + OW'(accept_s) - OW'(hs_s);

      new_rsp_s.opcode = is_get_s ? OP_ACK_DATA : OP_ACK;
      new_rsp_s.size   = tl_i.a_size;
      new_rsp_s.source = tl_i.a_source;
      new_rsp_s.data   = (is_get_s && !err_s) ? mem[idx_s] : {TL_DW{1'b0}};
      new_rsp_s.error  = err_s;
   end

   // Byte-lane memory writes on accept; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int i = 0; i < BW; i++) begin
            if (tl_i.a_mask[i]) begin
               mem[idx_s][8*i +: 8] <= tl_i.a_data[8*i +: 8];
            end
         end
      end
   end

   // Fixed-latency shift pipeline between accept and the response FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_r <= {RSP_LATENCY{1'b0}};
         for (int i = 0; i < RSP_LATENCY; i++) begin
            pipe_r[i] <= '0;
         end
      end else begin
         pipe_vld_r[0] <= accept_s;
         pipe_r[0]     <= new_rsp_s;
         for (int i = 1; i < RSP_LATENCY; i++) begin
            pipe_vld_r[i] <= pipe_vld_r[i-1];
            pipe_r[i]     <= pipe_r[i-1];
         end
      end
   end

   // Response FIFO; outstanding gating on a_ready guarantees it never overflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= {OW{1'b0}};
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            fifo_r[wr_ptr_r] <= pipe_r[RSP_LATENCY-1];
            wr_ptr_r         <= ptr_inc(wr_ptr_r);
         end
         if (hs_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         cnt_r <= cnt_r + OW'(push_s) - OW'(hs_s);
      end
   end

   // Outstanding count and registered a_ready derived from the next count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r     <= {OW{1'b0}};
         a_ready_r <= 1'b0;
      end else begin
         out_r     <= out_next_s;
         a_ready_r <= (out_next_s < DEPTH_C);
      end
   end

   assign outstanding_o = out_r;

   // D channel presents the FIFO head; all fields read zero while empty.
   always_comb begin
      tl_o         = '0;
      tl_o.a_ready = a_ready_r;
      if (cnt_r != {OW{1'b0}}) begin
         tl_o.d_valid  = 1'b1;
         tl_o.d_opcode = fifo_r[rd_ptr_r].opcode;
         tl_o.d_size   = fifo_r[rd_ptr_r].size;
         tl_o.d_source = fifo_r[rd_ptr_r].source;
         tl_o.d_data   = fifo_r[rd_ptr_r].data;
         tl_o.d_error  = fifo_r[rd_ptr_r].error;
      end else begin
         tl_o.d_valid  = 1'b0;
      end
   end

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Directed bench for tlul_sram_responder: queue/array reference model checked every cycle, plus literal spot checks.
// Honors TLUL_RSP_ALIGN_CHECK_EN the same way as the design.
module tb_tlul_sram_responder;
   import tlul_pkg::*;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int MEM_WORDS = 256;
   localparam int LAT = 1;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   tl_h2d_t tl_i;
   tl_d2h_t tl_o;
   logic [1:0] outstanding;

   always #5 clk = ~clk;

   tlul_sram_responder #(
      .BASE_ADDR(BASE), .MEM_WORDS(MEM_WORDS), .RSP_LATENCY(LAT), .RSP_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tl_i(tl_i), .tl_o(tl_o), .outstanding_o(outstanding)
   );

   typedef struct {
      logic [2:0]  opcode;
      logic [1:0]  size;
      logic [7:0]  source;
      logic [31:0] data;
      logic        error;
      bit          known;
      int          elig;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem_m [int];
   int          cyc = 0;
   bit          armed = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;

   logic [2:0]  last_opcode;
   logic [7:0]  last_source;
   logic [31:0] last_data;
   logic        last_error;
   int          last_hs_edge;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model of one accepted request: response contents and memory update.
   task automatic model_accept(input tl_h2d_t r, input int edge_idx);
      exp_t e;
      longint a;
      int word;
      bit get, put, err;
      int nbytes;
      logic [31:0] w;
      a    = longint'(r.a_address);
      get  = (r.a_opcode == 3'd4);
      put  = (r.a_opcode == 3'd0) || (r.a_opcode == 3'd1);
      err  = !(get || put) || !(a >= longint'(BASE) && a < longint'(BASE) + MEM_WORDS * 4);
      word = int'((a - longint'(BASE)) / 4);
`ifdef TLUL_RSP_ALIGN_CHECK_EN
      nbytes = 1 << r.a_size;
      if (r.a_size > 2) err = 1'b1;
      else if ((a % nbytes) != 0) err = 1'b1;
      else if (r.a_opcode == 3'd0 && r.a_mask != 4'(((1 << nbytes) - 1) << (a % 4))) err = 1'b1;
      if (get && r.a_mask == 4'd0) err = 1'b1;
`else
      nbytes = 0;
`endif
      e.opcode = get ? 3'd1 : 3'd0;
      e.size   = r.a_size;
      e.source = r.a_source;
      e.error  = err;
      e.data   = 32'd0;
      e.known  = 1'b1;
      e.elig   = edge_idx + LAT + 1;
      if (get && !err) begin
         if (mem_m.exists(word)) e.data = mem_m[word];
         else e.known = 1'b0;
      end
      if (put && !err && (mem_m.exists(word) || r.a_mask == 4'hF)) begin
         w = mem_m.exists(word) ? mem_m[word] : 32'd0;
         for (int i = 0; i < 4; i++) if (r.a_mask[i]) w[8*i +: 8] = r.a_data[8*i +: 8];
         mem_m[word] = w;
      end
      q.push_back(e);
   endtask

   // Monitor: track handshakes at each rising edge and advance the model.
   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         armed = 1'b0;
      end else begin
         if (tl_o.d_valid && tl_i.d_ready) begin
            if (q.size() > 0) void'(q.pop_front());
            last_opcode  = tl_o.d_opcode;
            last_source  = tl_o.d_source;
            last_data    = tl_o.d_data;
            last_error   = tl_o.d_error;
            last_hs_edge = cyc;
         end
         if (tl_i.a_valid && tl_o.a_ready) model_accept(tl_i, cyc);
         armed = 1'b1;
      end
      cyc <= cyc + 1;
   end

   // Compare: DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      bit exp_v;
      if (!rst_n) begin
         check("rst_tl_o", 64'(tl_o), 64'd0);
         check("rst_outstanding", 64'(outstanding), 64'd0);
      end else begin
         exp_v = 1'b0;
         if (q.size() > 0) exp_v = (q[0].elig <= cyc);
         check("d_valid", 64'(tl_o.d_valid), 64'(exp_v));
         check("a_ready", 64'(tl_o.a_ready), 64'(armed && q.size() < DEPTH));
         check("outstanding", 64'(outstanding), 64'(q.size()));
         if (exp_v && tl_o.d_valid) begin
            check("d_opcode", 64'(tl_o.d_opcode), 64'(q[0].opcode));
            check("d_source", 64'(tl_o.d_source), 64'(q[0].source));
            check("d_size", 64'(tl_o.d_size), 64'(q[0].size));
            check("d_error", 64'(tl_o.d_error), 64'(q[0].error));
            check("d_param_sink", 64'({tl_o.d_param, tl_o.d_sink}), 64'd0);
            if (q[0].known) check("d_data", 64'(tl_o.d_data), 64'(q[0].data));
         end
      end
   end

   // Drive one request from a falling edge until it is accepted (bounded).
   task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src,
                       output int acc_edge);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      acc_edge = -1;
      tl_i.a_valid   = 1'b1;
      tl_i.a_opcode  = op;
      tl_i.a_address = addr;
      tl_i.a_data    = data;
      tl_i.a_mask    = mask;
      tl_i.a_size    = size;
      tl_i.a_source  = src;
      while (!done && n < 100) begin
         @(posedge clk);
         if (tl_o.a_ready) begin
            done = 1'b1;
            acc_edge = cyc;
         end
         @(negedge clk);
         n++;
      end
      tl_i.a_valid = 1'b0;
      if (!done) begin
         n_checks++;
         $display("FAIL send_timeout: got no accept expected accept of src %0h", src);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int e1, e2, e3, pop_edge;
      tl_i = '0;
      tl_i.d_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check("a_ready_before_edge", 64'(tl_o.a_ready), 64'd0);
      @(negedge clk);
      check("a_ready_first_edge", 64'(tl_o.a_ready), 64'd1);

      // Full write then read back.
      send(OP_PUT_FULL, 32'h8000_0010, 32'h0000_ABCD, 4'hF, 2'd2, 8'h01, e1);
      drain();
      check("put_ack_op", 64'(last_opcode), 64'd0);
      check("put_ack_err", 64'(last_error), 64'd0);
      check("put_ack_src", 64'(last_source), 64'h01);
      check("put_latency", 64'(last_hs_edge - e1), 64'd2);
      send(OP_GET, 32'h8000_0010, 32'h0, 4'hF, 2'd2, 8'h03, e1);
      drain();
      check("get_op", 64'(last_opcode), 64'd1);
      check("get_data", 64'(last_data), 64'h0000_ABCD);
      check("get_src", 64'(last_source), 64'h03);
      check("get_latency", 64'(last_hs_edge - e1), 64'd2);

      // Partial write of the low half-word.
      send(OP_PUT_PARTIAL, 32'h8000_0010, 32'h1122_3344, 4'b0011, 2'd2, 8'h02, e1);
      send(OP_GET, 32'h8000_0010, 32'h0, 4'hF, 2'd2, 8'h04, e1);
      drain();
      check("partial_data", 64'(last_data), 64'h0000_3344);

      // Range errors, including one byte past the window, and the last word.
      send(OP_GET, 32'h4008_0000, 32'h0, 4'hF, 2'd2, 8'h05, e1);
      drain();
      check("oor_op", 64'(last_opcode), 64'd1);
      check("oor_err", 64'(last_error), 64'd1);
      check("oor_data", 64'(last_data), 64'd0);
      send(OP_PUT_FULL, 32'h4000_0010, 32'hFFFF_FFFF, 4'hF, 2'd2, 8'h06, e1);
      send(OP_PUT_FULL, 32'h8000_0400, 32'hFFFF_FFFF, 4'hF, 2'd2, 8'h07, e1);
      send(OP_PUT_FULL, 32'h8000_03FC, 32'h5A5A_0001, 4'hF, 2'd2, 8'h08, e1);
      send(OP_GET, 32'h8000_03FC, 32'h0, 4'hF, 2'd2, 8'h09, e1);
      drain();
      check("last_word", 64'(last_data), 64'h5A5A_0001);
      send(OP_GET, 32'h8000_0010, 32'h0, 4'hF, 2'd2, 8'h0A, e1);
      drain();
      check("oor_no_write", 64'(last_data), 64'h0000_3344);

      // Back-pressure: two outstanding, third waits for the first pop.
      tl_i.d_ready = 1'b0;
      fork
         begin
            send(OP_GET, 32'h8000_0010, 32'h0, 4'hF, 2'd2, 8'h11, e1);
            send(OP_GET, 32'h8000_03FC, 32'h0, 4'hF, 2'd2, 8'h12, e2);
            send(OP_GET, 32'h8000_0010, 32'h0, 4'hF, 2'd2, 8'h13, e3);
         end
         begin
            repeat (6) @(negedge clk);
            check("full_a_ready", 64'(tl_o.a_ready), 64'd0);
            check("full_outstanding", 64'(outstanding), 64'd2);
            pop_edge = cyc;
            tl_i.d_ready = 1'b1;
         end
      join
      check("third_accept_edge", 64'(e3 - pop_edge), 64'd1);
      drain();
      check("order_last_src", 64'(last_source), 64'h13);

      // Unsupported opcode.
      send(3'h5, 32'h8000_0010, 32'h0, 4'hF, 2'd2, 8'h0A, e1);
      drain();
      check("badop_op", 64'(last_opcode), 64'd0);
      check("badop_err", 64'(last_error), 64'd1);

      // Reset with two responses in flight.
      tl_i.d_ready = 1'b0;
      send(OP_GET, 32'h8000_0010, 32'h0, 4'hF, 2'd2, 8'h21, e1);
      send(OP_GET, 32'h8000_0010, 32'h0, 4'hF, 2'd2, 8'h22, e2);
      repeat (2) @(negedge clk);
      check("pre_rst_outstanding", 64'(outstanding), 64'd2);
      #2 rst_n = 1'b0;
      #1 check("rst_d_valid_now", 64'(tl_o.d_valid), 64'd0);
      check("rst_a_ready_now", 64'(tl_o.a_ready), 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      tl_i.d_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_outstanding", 64'(outstanding), 64'd0);
      check("post_rst_d_valid", 64'(tl_o.d_valid), 64'd0);
      send(OP_GET, 32'h8000_03FC, 32'h0, 4'hF, 2'd2, 8'h23, e1);
      drain();
      check("mem_kept", 64'(last_data), 64'h5A5A_0001);

      // Misaligned word read: checked only with the alignment option.
      send(OP_PUT_FULL, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 2'd2, 8'h0B, e1);
      send(OP_GET, 32'h8000_0002, 32'h0, 4'hF, 2'd2, 8'h0C, e1);
      drain();
`ifdef TLUL_RSP_ALIGN_CHECK_EN
      check("misalign_err", 64'(last_error), 64'd1);
      check("misalign_data", 64'(last_data), 64'd0);
`else
      check("misalign_err", 64'(last_error), 64'd0);
      check("misalign_data", 64'(last_data), 64'hDEAD_BEEF);
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
